// File: rtl/odd_parity_serial_tx.sv
// odd_parity_serial_tx: sends one byte plus the parity bit from the upstream odd-parity
// generator as an 11-bit async frame: start, 8 data bits LSB first, parity, stop.
// The parity bit is sent exactly as received. par_err records whether that bit was good odd parity.
module odd_parity_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              valid_in,
  output logic              ready,
  output logic              busy,
  output logic              tx,
  output logic              done,
  output logic              par_err
);

  localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              par_bit, par_bit_nxt;
  logic              tx_nxt;
  logic              done_nxt;
  logic              par_err_nxt;
  logic              bit_end;

  assign bit_end = (timer == TIMER_LAST);
  assign busy    = (state != IDLE);

  // Next-state logic. tx_nxt is the line level for the next cycle, so tx can stay a plain flop.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    par_bit_nxt = par_bit;
    tx_nxt      = tx;
    done_nxt    = 1'b0;
    par_err_nxt = par_err;
    case (state)
      IDLE: begin
        tx_nxt    = 1'b1;
        timer_nxt = '0;
        if (valid_in && ready) begin
          state_nxt   = START;
          shreg_nxt   = data_in;
          par_bit_nxt = parity_in;
          par_err_nxt = ~(^{data_in, parity_in});
          tx_nxt      = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          timer_nxt   = '0;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
          tx_nxt      = shreg[0];
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_nxt = '0;
          if (bit_idx == IDX_LAST) begin
            state_nxt = PARITY;
            tx_nxt    = par_bit;
          end else begin
            bit_idx_nxt = bit_idx + IDX_W'(1);
            shreg_nxt   = shreg >> 1;
            tx_nxt      = shreg[1];
          end
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          timer_nxt = '0;
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_nxt = '0;
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  // State and output registers. Reset drops any frame in flight and returns the line to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      ready   <= 1'b1;
      done    <= 1'b0;
      par_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_bit_nxt;
      tx      <= tx_nxt;
      ready   <= (state_nxt == IDLE);
      done    <= done_nxt;
      par_err <= par_err_nxt;
    end
  end

endmodule
